dmem_access_m: RTL
==================

DMEM_ACCESS_M -- requirements
Module: dmem_access_M

Interface
REQ-001 Parameter: TIMEOUT_CYC, 255, max BUSY cycles waiting for mem_ack before abort (1..255).
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 memwrite_M  input  1  store op in M stage.
REQ-005 memtoreg_M  input  1  word load (lw) in M stage.
REQ-006 lb_memtoreg_M  input  1  byte load (lb) in M stage.
REQ-007 sb  input  1  store is byte-wide (qualifies memwrite_M).
REQ-008 addr_M  input  32  byte address from ALU.
REQ-009 wdata_M  input  32  store data.
REQ-010 stall_M  output  1  freeze pipeline while access pending.
REQ-011 rdata_M  output  32  load result, valid in DONE.
REQ-012 bus_err  output  1  one-cycle pulse on timeout.
REQ-013 misalign  output  1  one-cycle pulse on misaligned word access.
REQ-014 mem_req/mem_we  output  1/1  bus request, write enable.
REQ-015 mem_addr  output  32  word address {addr_M[31:2],2'b00}.
REQ-016 mem_be/mem_wdata  output  4/32  byte enables, write data.
REQ-017 mem_ack/mem_rdata  input  1/32  bus completion, read word.

Function
REQ-018 op = memwrite_M | memtoreg_M | lb_memtoreg_M; store has priority if load and store both asserted.
REQ-019 States IDLE, BUSY, DONE; IDLE->BUSY when op; BUSY->DONE on mem_ack or timeout; DONE->IDLE unconditionally.
REQ-020 stall_M = op & (state != DONE), combinational; DONE releases pipeline for exactly one cycle.
REQ-021 mem_addr/mem_be/mem_wdata/mem_we registered on IDLE->BUSY and held stable throughout BUSY; mem_req = (state==BUSY).
REQ-022 sw: mem_be=4'b1111, mem_wdata=wdata_M; sb: mem_be=4'b0001<<addr_M[1:0], mem_wdata={4{wdata_M[7:0]}}.
REQ-023 lw: rdata_M=mem_rdata; lb: byte lane addr_M[1:0] (lane 0 = bits 7:0), sign-extended to 32; captured on ack edge.
REQ-024 Minimum latency: ack in first BUSY cycle -> stall_M high 2 cycles, rdata_M valid in cycle 3.
REQ-025 8-bit counter clears on entering BUSY, increments per BUSY cycle without ack; at TIMEOUT_CYC -> DONE, bus_err=1 for the DONE cycle, rdata_M=0.
REQ-026 mem_ack ignored outside BUSY; ack in same cycle as timeout counts as success (no bus_err).
REQ-027 Stores leave rdata_M unchanged.

Reset
REQ-028 reset_n low: state IDLE, counter 0, every output 0 (stall_M follows op combinationally, deasserted once op drops).
REQ-029 Reset assertion mid-BUSY drops mem_req immediately; transaction abandoned, no bus_err.

Configuration
REQ-030 DM_MISALIGN_CHECK_EN defined: lw/sw with addr_M[1:0]!=0 go IDLE->DONE, no mem_req, misalign=1 in DONE, rdata_M=0.
REQ-031 DM_MISALIGN_CHECK_EN undefined: misalign tied 0, addr_M[1:0] ignored for word ops, all ops use bus.

Verification
REQ-032 sw addr 0x10, data 0xDEADBEEF, ack after 1 cycle -> mem_be=1111, mem_addr=0x10, stall 2 cycles.
REQ-033 sb addr 0x13, data 0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5.
REQ-034 lb addr 0x22, mem_rdata=0x00F30000 -> rdata_M=0xFFFFFFF3; lw same -> 0x00F30000.
REQ-035 lw, ack never returns, TIMEOUT_CYC=4 -> DONE after 4 BUSY cycles, bus_err pulse, rdata_M=0.
REQ-036 lw addr 0x06 with macro -> misalign pulse, no mem_req; without macro -> mem_addr=0x04.
REQ-037 reset_n low in 2nd BUSY cycle -> mem_req 0 same cycle, IDLE after release.

Source files
------------

// File: rtl/dmem_access_m_if.sv
// Data-memory bus between the M-stage access unit (master) and memory (slave).
// Request fields are stable for the whole request; completion is a single mem_ack pulse.
interface dmem_access_m_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dmem_access_m.sv
// M-stage load/store unit: lw/lb/sw/sb over a req/ack bus, with timeout abort (optional DM_MISALIGN_CHECK_EN).
// Latency: ack in the first BUSY cycle gives a 2-cycle stall, with the result valid in the third cycle.
// Backpressure: stall_M holds the pipeline until DONE; no ack within TIMEOUT_CYC cycles ends in bus_err.
module dmem_access_m #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memwrite_M,
    input  logic        memtoreg_M,
    input  logic        lb_memtoreg_M,
    input  logic        sb,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    output logic        stall_M,
    output logic [31:0] rdata_M,
    output logic        bus_err,
    output logic        misalign,
    dmem_access_m_if.master mem
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ld_q, ld_d;
    logic        lb_q, lb_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;

    logic        op;
    logic        byte_op;
    logic        misal;
    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;

    assign op = memwrite_M | memtoreg_M | lb_memtoreg_M;
    // Stores win over loads; a load with both lw and lb set is treated as lw.
    assign byte_op = memwrite_M ? sb : (lb_memtoreg_M & ~memtoreg_M);

`ifdef DM_MISALIGN_CHECK_EN
    assign misal = ~byte_op & (addr_M[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    assign rd_shift = mem.mem_rdata >> {lane_q, 3'b000};
    assign rd_byte  = rd_shift[7:0];

    assign stall_M       = op & (state_q != DONE);
    assign rdata_M       = rdata_q;
    assign bus_err       = err_q;
    assign misalign      = mis_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        lb_d    = lb_q;
        lane_d  = lane_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        mis_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (op) begin
                    if (misal) begin
                        state_d = DONE;
                        mis_d   = 1'b1;
                        if (!memwrite_M) rdata_d = '0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = memwrite_M;
                        addr_d  = {addr_M[31:2], 2'b00};
                        be_d    = byte_op ? (4'b0001 << addr_M[1:0]) : 4'b1111;
                        wdata_d = !memwrite_M ? '0 : (sb ? {4{wdata_M[7:0]}} : wdata_M);
                        ld_d    = ~memwrite_M;
                        lb_d    = byte_op;
                        lane_d  = addr_M[1:0];
                    end
                end
            end
            BUSY: begin
                // An ack arriving on the timeout cycle still completes normally.
                if (mem.mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (ld_q) rdata_d = lb_q ? {{24{rd_byte[7]}}, rd_byte} : mem.mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    if (ld_q) rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            ld_q    <= 1'b0;
            lb_q    <= 1'b0;
            lane_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            lb_q    <= lb_d;
            lane_q  <= lane_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

endmodule
